spi_slave_frame: RTL and testbench

- Parametrised successor to the single-mode SPI slave in the FND counter path.
- Full-duplex SPI slave supporting all four CPOL/CPHA modes, with configurable word width and words per frame.
- Synchronises the external sclk, mosi and ss_n into the system clock domain and assembles multi-word frames.
- Presents a completed frame as one wide word with a one-cycle valid strobe and flags aborted frames. Sits between the board SPI pins and the display/counter logic.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_slave_frame_if.sv | 42 ++++
 rtl/spi_sync_edge.sv | 42 ++++
 rtl/spi_slave_frame.sv | 200 ++++++++++++++++++++
 tb/tb_spi_slave_frame.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and helpers for the framed SPI slave.
//   spi_state_t    : IDLE / ACTIVE state encoding of the frame FSM
//   frame_w()      : frame width in bits (WORD_W * WORDS)
//   sample_on_rise : 1 when mosi is sampled on the rising sclk edge
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  function automatic int frame_w(input int word_w, input int words);
    return word_w * words;
  endfunction

  // The leading edge is rising for CPOL=0 and falling for CPOL=1. The sample
  // edge is the leading edge for CPHA=0 and the trailing edge for CPHA=1.
  // Together: sampling happens on the rising edge exactly when CPOL == CPHA.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_slave_frame_if.sv
// -----------------------------------------------------------------------------
// spi_slave_frame_if
// Pin-side and frame-side signals of the framed SPI slave.
//   sclk, mosi, ss_n : SPI pins from the master (asynchronous to clk)
//   tx_data          : frame to transmit, captured at frame start
//   miso, miso_oe    : serial data out and its output enable
//   rx_data          : last complete frame, first word in the MSBs
//   rx_valid         : one-cycle strobe when rx_data updates
//   frame_err        : one-cycle strobe when a frame is aborted
//   busy             : slave is inside an ss_n-low window
// Modports: slave (the SPI slave) and master (whatever drives the pins).
// -----------------------------------------------------------------------------
interface spi_slave_frame_if
  import spi_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int WORDS  = 2
);
  localparam int FRAME_W = frame_w(WORD_W, WORDS);

  logic               sclk;
  logic               mosi;
  logic               ss_n;
  logic [FRAME_W-1:0] tx_data;
  logic               miso;
  logic               miso_oe;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic               frame_err;
  logic               busy;

  modport slave (
    input  sclk, mosi, ss_n, tx_data,
    output miso, miso_oe, rx_data, rx_valid, frame_err, busy
  );

  modport master (
    output sclk, mosi, ss_n, tx_data,
    input  miso, miso_oe, rx_data, rx_valid, frame_err, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchroniser for one asynchronous input, with edge detection
// between the last synchronised stage and one extra delay flop.
//   clk, reset : system clock, asynchronous active-high reset
//   d_i        : asynchronous input
//   q_o        : synchronised level
//   rise_o     : one-cycle pulse on a synchronised 0->1 transition
//   fall_o     : one-cycle pulse on a synchronised 1->0 transition
// RESET_VAL should match the idle level of the input so that leaving reset
// does not fabricate an edge.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave_frame.sv
// -----------------------------------------------------------------------------
// spi_slave_frame
// Full-duplex SPI slave for any CPOL/CPHA, assembling WORDS words of WORD_W
// bits into one frame. sclk/mosi/ss_n are synchronised into clk, so sclk must
// stay at or below f_clk/8.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : spi_slave_frame_if.slave (SPI pins, tx/rx frames, strobes, busy)
// Frames may follow each other back to back inside one ss_n-low window.
// Releasing ss_n anywhere but on a frame boundary raises frame_err and drops
// the partial frame.
// -----------------------------------------------------------------------------
module spi_slave_frame
  import spi_pkg::*;
#(
  parameter int   WORD_W      = 8,
  parameter int   WORDS       = 2,
  parameter logic CPOL        = 1'b0,
  parameter logic CPHA        = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  spi_slave_frame_if.slave bus
);

  localparam int   FRAME_W        = frame_w(WORD_W, WORDS);
  localparam int   BIT_CW         = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int   WORD_CW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic SAMPLE_ON_RISE = sample_on_rise(CPOL, CPHA);
  localparam logic [BIT_CW-1:0]  LAST_BIT  = BIT_CW'(WORD_W - 1);
  localparam logic [WORD_CW-1:0] LAST_WORD = WORD_CW'(WORDS - 1);

  // Index 0 = sclk, 1 = mosi, 2 = ss_n. Reset values equal the idle levels.
  localparam logic [2:0] SYNC_RST = {1'b1, 1'b0, CPOL};

  logic [2:0] pin_in;
  logic [2:0] pin_s;
  logic [2:0] pin_rise;
  logic [2:0] pin_fall;

  assign pin_in = {bus.ss_n, bus.mosi, bus.sclk};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (SYNC_RST[gi])
    ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .d_i    (pin_in[gi]),
      .q_o    (pin_s[gi]),
      .rise_o (pin_rise[gi]),
      .fall_o (pin_fall[gi])
    );
  end

  logic mosi_s;
  logic sample_edge;
  logic shift_edge;
  logic ss_fall;
  logic ss_rise;

  assign mosi_s      = pin_s[1];
  assign sample_edge = SAMPLE_ON_RISE ? pin_rise[0] : pin_fall[0];
  assign shift_edge  = SAMPLE_ON_RISE ? pin_fall[0] : pin_rise[0];
  assign ss_fall     = pin_fall[2];
  assign ss_rise     = pin_rise[2];

  spi_state_t          state_q, state_d;
  logic [FRAME_W-1:0]  tx_sr_q, tx_sr_d;
  logic [FRAME_W-1:0]  rx_sr_q, rx_sr_d;
  logic [BIT_CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_CW-1:0]  word_cnt_q, word_cnt_d;
  logic                miso_q, miso_d;
  logic [FRAME_W-1:0]  rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;
  // done: last bit of a frame was sampled last cycle; hand the frame over now.
  logic                done_q, done_d;
  // skip: CPHA=0 only; the shift edge right after a frame's final sample
  // presents the reloaded MSB instead of shifting it away.
  logic                skip_q, skip_d;

  logic [FRAME_W:0]    rx_shift;
  logic [FRAME_W-1:0]  tx_shift;

  assign rx_shift = {rx_sr_q, mosi_s};
  assign tx_shift = tx_sr_q << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
      skip_q      <= skip_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    done_d      = 1'b0;
    skip_d      = skip_q;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          tx_sr_d    = bus.tx_data;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          skip_d     = 1'b0;
          // CPHA=0: the first bit must be on miso before the first edge.
          if (!CPHA) miso_d = bus.tx_data[FRAME_W-1];
        end
      end

      ACTIVE: begin
        if (done_q) begin
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          tx_sr_d    = bus.tx_data;
          skip_d     = !CPHA;
        end

        // ss_n release wins over a coincident sclk edge.
        if (ss_rise) begin
          state_d = IDLE;
          if ((bit_cnt_q != '0) || (word_cnt_q != '0)) frame_err_d = 1'b1;
        end else if (sample_edge) begin
          rx_sr_d = rx_shift[FRAME_W-1:0];
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_d = '0;
              done_d     = 1'b1;
            end else begin
              word_cnt_d = word_cnt_q + WORD_CW'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CW'(1);
          end
        end else if (shift_edge) begin
          if (skip_q) begin
            skip_d = 1'b0;
            miso_d = tx_sr_q[FRAME_W-1];
          end else if (CPHA) begin
            // CPHA=1: present the current MSB, then move on to the next bit.
            miso_d  = tx_sr_q[FRAME_W-1];
            tx_sr_d = tx_shift;
          end else begin
            // CPHA=0: the MSB is already out; present the next bit.
            tx_sr_d = tx_shift;
            miso_d  = tx_shift[FRAME_W-1];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.miso      = miso_q;
  assign bus.miso_oe   = (state_q == ACTIVE);
  assign bus.busy      = (state_q == ACTIVE);
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;

  logic unused_sync;
  assign unused_sync = ^{pin_s[0], pin_s[2], pin_rise[1], pin_fall[1], rx_shift[FRAME_W]};

endmodule

// File: tb/tb_spi_slave_frame.sv
// Drives four slave instances (SPI modes 0..3) from one logical SPI master.
// The logical sclk idles at 0; each instance sees it XOR its CPOL, so a
// logical rising edge is always the leading edge.
module tb_spi_slave_frame;
  import spi_pkg::*;

  localparam int WORD_W = 8;
  localparam int WORDS  = 2;
  localparam int F      = WORD_W * WORDS;
  localparam int HP     = 80;  // sclk half period = 8 clk periods

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         sclk_lvl;
  logic         mosi_pin;
  logic [3:0]   ss_vec;
  logic [F-1:0] tx_word;

  logic [3:0]   miso_a, oe_a, valid_a, err_a, busy_a;
  logic [F-1:0] rxd_a [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    spi_slave_frame_if #(.WORD_W(WORD_W), .WORDS(WORDS)) bus ();

    assign bus.sclk    = sclk_lvl ^ (gi >= 2);
    assign bus.mosi    = mosi_pin;
    assign bus.ss_n    = ss_vec[gi];
    assign bus.tx_data = tx_word;

    spi_slave_frame #(
      .WORD_W      (WORD_W),
      .WORDS       (WORDS),
      .CPOL        (gi >= 2),
      .CPHA        ((gi % 2) == 1),
      .SYNC_STAGES (2)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign miso_a[gi]  = bus.miso;
    assign oe_a[gi]    = bus.miso_oe;
    assign valid_a[gi] = bus.rx_valid;
    assign err_a[gi]   = bus.frame_err;
    assign busy_a[gi]  = bus.busy;
    assign rxd_a[gi]   = bus.rx_data;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: last frame each instance should be holding.
  logic [F-1:0] model_rx [4];

  // Pulse monitors and miso edge-placement monitor.
  int vrise [4];
  int vhigh [4];
  int erise [4];
  int ehigh [4];
  int viol = 0;
  logic [3:0] valid_p = '0, err_p = '0, miso_p = '0;
  int cur_mode  = -1;
  int edge_kind = 3;  // 0: since ss_n fall, 1: after sample edge, 2: after shift edge, 3: idle

  initial begin
    for (int i = 0; i < 4; i++) begin
      vrise[i] = 0; vhigh[i] = 0; erise[i] = 0; ehigh[i] = 0; model_rx[i] = '0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (valid_a[i] === 1'b1) vhigh[i] <= vhigh[i] + 1;
      if (valid_a[i] === 1'b1 && valid_p[i] !== 1'b1) vrise[i] <= vrise[i] + 1;
      if (err_a[i] === 1'b1) ehigh[i] <= ehigh[i] + 1;
      if (err_a[i] === 1'b1 && err_p[i] !== 1'b1) erise[i] <= erise[i] + 1;
    end
    if (cur_mode >= 0 && miso_a[cur_mode] !== miso_p[cur_mode]) begin
      if (edge_kind == 1 || edge_kind == 3 || (edge_kind == 0 && (cur_mode % 2) == 1))
        viol <= viol + 1;
    end
    valid_p <= valid_a;
    err_p   <= err_a;
    miso_p  <= miso_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ss_low(input int m);
    ss_vec    = 4'hF;
    ss_vec[m] = 1'b0;
    cur_mode  = m;
    edge_kind = 0;
    #HP;
  endtask

  task automatic ss_high();
    #HP;
    ss_vec    = 4'hF;
    edge_kind = 3;
    #(3 * HP);
  endtask

  // Clocks nbits bits of din (MSB first) and collects miso at each sample edge.
  // next_tx is applied during the last bit, ahead of any frame-end reload.
  task automatic xfer(input int m, input logic [F-1:0] din, input int nbits,
                      input logic [F-1:0] next_tx, output logic [F-1:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i == nbits - 1) tx_word = next_tx;
      if ((m % 2) == 0) begin
        mosi_pin = din[F-1-i];
        #HP;
        got = {got[F-2:0], miso_a[m]};
        sclk_lvl = 1'b1; edge_kind = 1;
        #HP;
        sclk_lvl = 1'b0; edge_kind = 2;
      end else begin
        sclk_lvl = 1'b1; edge_kind = 2;
        mosi_pin = din[F-1-i];
        #HP;
        got = {got[F-2:0], miso_a[m]};
        sclk_lvl = 1'b0; edge_kind = 1;
        #HP;
      end
    end
  endtask

  task automatic full_frame(input int m, input logic [F-1:0] din, input logic [F-1:0] tx);
    int v0, vh0, e0, x0;
    logic [F-1:0] got;
    v0 = vrise[m]; vh0 = vhigh[m]; e0 = erise[m]; x0 = viol;
    tx_word = tx;
    ss_low(m);
    xfer(m, din, F, tx, got);
    ss_high();
    model_rx[m] = din;
    $display("frame mode=%0d mosi=0x%04h tx=0x%04h rx_data=0x%04h miso=0x%04h", m, din, tx, rxd_a[m], got);
    chk($sformatf("m%0d_rx_data", m), 32'(rxd_a[m]), 32'(model_rx[m]));
    chk($sformatf("m%0d_rx_valid_pulses", m), vrise[m] - v0, 1);
    chk($sformatf("m%0d_rx_valid_width", m), vhigh[m] - vh0, 1);
    chk($sformatf("m%0d_frame_err", m), erise[m] - e0, 0);
    chk($sformatf("m%0d_miso_stream", m), 32'(got), 32'(tx));
    chk($sformatf("m%0d_miso_edges", m), viol - x0, 0);
  endtask

  task automatic back_to_back(input int m);
    int v0, e0, x0;
    logic [F-1:0] tx0, tx1, d0, d1, got0, got1;
    tx0 = F'($urandom); tx1 = F'($urandom);
    d0 = 16'hFFFF; d1 = 16'h0001;
    v0 = vrise[m]; e0 = erise[m]; x0 = viol;
    tx_word = tx0;
    ss_low(m);
    xfer(m, d0, F, tx1, got0);
    model_rx[m] = d0;
    $display("b2b1 mode=%0d rx_data=0x%04h miso=0x%04h", m, rxd_a[m], got0);
    chk($sformatf("m%0d_b2b_rx1", m), 32'(rxd_a[m]), 32'(model_rx[m]));
    chk($sformatf("m%0d_b2b_valid1", m), vrise[m] - v0, 1);
    chk($sformatf("m%0d_b2b_miso1", m), 32'(got0), 32'(tx0));
    xfer(m, d1, F, tx1, got1);
    ss_high();
    model_rx[m] = d1;
    $display("b2b2 mode=%0d rx_data=0x%04h miso=0x%04h", m, rxd_a[m], got1);
    chk($sformatf("m%0d_b2b_rx2", m), 32'(rxd_a[m]), 32'(model_rx[m]));
    chk($sformatf("m%0d_b2b_valid2", m), vrise[m] - v0, 2);
    chk($sformatf("m%0d_b2b_miso2", m), 32'(got1), 32'(tx1));
    chk($sformatf("m%0d_b2b_err", m), erise[m] - e0, 0);
    chk($sformatf("m%0d_b2b_edges", m), viol - x0, 0);
  endtask

  initial begin
    int m, v0, e0, eh0;
    logic [F-1:0] got;
    logic oe_seen, busy_seen;

    reset = 1'b1; sclk_lvl = 1'b0; mosi_pin = 1'b0; ss_vec = 4'hF; tx_word = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("m%0d_reset_outs", i),
          {rxd_a[i], valid_a[i], err_a[i], busy_a[i], miso_a[i], oe_a[i]}, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Reference frame in every mode, then one random frame per mode.
    for (int i = 0; i < 4; i++) full_frame(i, 16'hA53C, 16'h1234);
    for (int i = 0; i < 4; i++) full_frame(i, F'($urandom), F'($urandom));

    // Back-to-back frames: mode 0 plus one random mode.
    back_to_back(0);
    back_to_back(int'($urandom_range(1, 3)));

    // Aborted frame after 11 bits, then a good frame.
    m = int'($urandom_range(0, 3));
    v0 = vrise[m]; e0 = erise[m]; eh0 = ehigh[m];
    tx_word = F'($urandom);
    ss_low(m);
    xfer(m, F'($urandom), 11, tx_word, got);
    ss_high();
    $display("abort mode=%0d rx_data=0x%04h", m, rxd_a[m]);
    chk($sformatf("m%0d_abort_err_pulses", m), erise[m] - e0, 1);
    chk($sformatf("m%0d_abort_err_width", m), ehigh[m] - eh0, 1);
    chk($sformatf("m%0d_abort_no_valid", m), vrise[m] - v0, 0);
    chk($sformatf("m%0d_abort_rx_kept", m), 32'(rxd_a[m]), 32'(model_rx[m]));
    full_frame(m, 16'h55AA, F'($urandom));

    // Asynchronous reset after bit 5, off the clock edge.
    m = int'($urandom_range(0, 3));
    tx_word = F'($urandom);
    ss_low(m);
    xfer(m, F'($urandom), 5, tx_word, got);
    cur_mode = -1;
    #3 reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      model_rx[i] = '0;
      $display("async_reset inst=%0d rx_data=0x%04h", i, rxd_a[i]);
      chk($sformatf("m%0d_async_reset_outs", i),
          {rxd_a[i], valid_a[i], err_a[i], busy_a[i], miso_a[i], oe_a[i]}, {model_rx[i], 5'b0});
    end
    ss_vec = 4'hF; sclk_lvl = 1'b0; edge_kind = 3;
    #HP;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    full_frame(m, 16'h0F0F, F'($urandom));

    // sclk activity with ss_n high must be ignored.
    m = int'($urandom_range(0, 3));
    cur_mode = m; edge_kind = 3;
    v0 = vrise[m]; e0 = erise[m];
    oe_seen = 1'b0; busy_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mosi_pin = 1'($urandom);
      sclk_lvl = ~sclk_lvl;
      #(HP / 2);
      oe_seen   = oe_seen | oe_a[m];
      busy_seen = busy_seen | busy_a[m];
      #(HP / 2);
    end
    #(2 * HP);
    $display("idle_sclk mode=%0d oe=%0b busy=%0b", m, oe_seen, busy_seen);
    chk($sformatf("m%0d_idle_no_valid", m), vrise[m] - v0, 0);
    chk($sformatf("m%0d_idle_no_err", m), erise[m] - e0, 0);
    chk($sformatf("m%0d_idle_oe", m), 32'(oe_seen), 0);
    chk($sformatf("m%0d_idle_busy", m), 32'(busy_seen), 0);
    chk($sformatf("m%0d_idle_rx_kept", m), 32'(rxd_a[m]), 32'(model_rx[m]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
